// File: rtl/pipeline_hold_ctrl_pkg.sv
// Shared definitions for the pipeline hold/flush scheduler: FSM state encoding,
// default parameters, stage indices and per-stage control bundles.
package pipeline_hold_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_EX_BUSY  = 2'd1,
    ST_MEM_WAIT = 2'd2
  } hold_state_e;

  localparam int unsigned MULDIV_LAT_DEF = 32;
  localparam int unsigned CNT_W_DEF      = 6;
  localparam int unsigned PERF_W_DEF     = 32;

  // Stage indices shared with the hazard/forwarding units.
  localparam int unsigned STAGE_IF  = 0;
  localparam int unsigned STAGE_ID  = 1;
  localparam int unsigned STAGE_EX  = 2;
  localparam int unsigned STAGE_MEM = 3;
  localparam int unsigned STAGE_WB  = 4;

  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } stage_en_t;

  typedef struct packed {
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } stage_flush_t;

endpackage

// File: rtl/pipeline_hold_ctrl_if.sv
// Hazard-side inputs and stage-register controls of the hold scheduler.
// The slave modport is the scheduler; the master modport is its environment.
interface pipeline_hold_ctrl_if #(
  parameter int unsigned PERF_W = 32
);

  logic              load_use_ID;
  logic              branch_taken_EX;
  logic              muldiv_EX;
  logic              dmem_req_MEM;
  logic              dmem_ready;
  logic              en_PC;
  logic              en_IF_ID;
  logic              en_ID_EX;
  logic              en_EX_MEM;
  logic              en_MEM_WB;
  logic              flush_IF_ID;
  logic              flush_ID_EX;
  logic              flush_EX_MEM;
  logic              flush_MEM_WB;
  logic              redirect_PC;
  logic              muldiv_done;
  logic [1:0]        busy_state;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output load_use_ID, branch_taken_EX, muldiv_EX, dmem_req_MEM, dmem_ready,
    input  en_PC, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB,
    input  flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB,
    input  redirect_PC, muldiv_done, busy_state, stall_cycles
  );

  modport slave (
    input  load_use_ID, branch_taken_EX, muldiv_EX, dmem_req_MEM, dmem_ready,
    output en_PC, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB,
    output flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB,
    output redirect_PC, muldiv_done, busy_state, stall_cycles
  );

endinterface

// File: rtl/pipeline_hold_ctrl_sat_counter.sv
// hold_sat_counter: W-bit incrementer that sticks at all-ones, with a
// synchronous clear that takes priority over increment.
module hold_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hold_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline: merges load-use and
// branch hazards with multi-cycle mul/div in EX and data-memory waits in MEM.
module pipeline_hold_ctrl
  import pipeline_hold_ctrl_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = MULDIV_LAT_DEF, // >= 2
  parameter int unsigned CNT_W      = CNT_W_DEF,      // must hold MULDIV_LAT-2
  parameter int unsigned PERF_W     = PERF_W_DEF
) (
  input logic                 clk,
  input logic                 rst,
  pipeline_hold_ctrl_if.slave bus
);

  hold_state_e      state_q;
  hold_state_e      state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  stage_en_t    en;
  stage_flush_t flush;
  logic         redirect;
  logic         done;
  logic         memstall;

  assign memstall = bus.dmem_req_MEM & ~bus.dmem_ready;

  // Outputs are Mealy: a decision made this cycle gates the stage registers
  // at the coming edge, so there is no time to register them.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    en       = '1;
    flush    = '0;
    redirect = 1'b0;
    done     = 1'b0;
    state_d  = state_q;
    cnt_d    = cnt_q;

    if (rst) begin
      flush = '1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (memstall) begin
            en           = '0;
            flush.mem_wb = 1'b1;
            state_d      = ST_MEM_WAIT;
          end else if (bus.muldiv_EX) begin
            en.pc        = 1'b0;
            en.if_id     = 1'b0;
            en.id_ex     = 1'b0;
            flush.ex_mem = 1'b1;
            cnt_d        = CNT_W'(MULDIV_LAT - 2);
            state_d      = ST_EX_BUSY;
          end else if (bus.branch_taken_EX) begin
            // The instruction in ID is wrong-path, so its load-use hazard is moot.
            flush.if_id = 1'b1;
            flush.id_ex = 1'b1;
            redirect    = 1'b1;
          end else if (bus.load_use_ID) begin
            en.pc       = 1'b0;
            en.if_id    = 1'b0;
            flush.id_ex = 1'b1;
          end
        end

        ST_MEM_WAIT: begin
          // Stages are frozen, so branch and load-use wait until release.
          if (!bus.dmem_ready) begin
            en           = '0;
            flush.mem_wb = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end

        ST_EX_BUSY: begin
          // muldiv_EX is still high in the release cycle; it is not sampled here.
          if (cnt_q != '0) begin
            en.pc        = 1'b0;
            en.if_id     = 1'b0;
            en.id_ex     = 1'b0;
            flush.ex_mem = 1'b1;
            cnt_d        = cnt_q - CNT_W'(1);
          end else begin
            done    = 1'b1;
            state_d = ST_RUN;
          end
        end

        default: state_d = ST_RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  hold_sat_counter #(
    .W (PERF_W)
  ) u_stall_cnt (
    .clk   (clk),
    .clr_i (rst),
    .inc_i (~en.pc & ~rst),
    .cnt_o (bus.stall_cycles)
  );

  assign bus.en_PC        = en.pc;
  assign bus.en_IF_ID     = en.if_id;
  assign bus.en_ID_EX     = en.id_ex;
  assign bus.en_EX_MEM    = en.ex_mem;
  assign bus.en_MEM_WB    = en.mem_wb;
  assign bus.flush_IF_ID  = flush.if_id;
  assign bus.flush_ID_EX  = flush.id_ex;
  assign bus.flush_EX_MEM = flush.ex_mem;
  assign bus.flush_MEM_WB = flush.mem_wb;
  assign bus.redirect_PC  = redirect;
  assign bus.muldiv_done  = done;
  assign bus.busy_state   = state_q;

endmodule

// File: tb/tb_pipeline_hold_ctrl.sv
// Self-checking bench: two scheduler instances (short latency / wide counter and
// longer latency / narrow counter) checked against a behavioural model.
module tb_pipeline_hold_ctrl;

  localparam int LAT_A = 4;
  localparam int PW_A  = 32;
  localparam int LAT_B = 8;
  localparam int PW_B  = 4;

  localparam int MODE_RUN = 0;
  localparam int MODE_MUL = 1;
  localparam int MODE_MEM = 2;

  typedef struct {
    int     mode;
    int     rem;     // EX_BUSY cycles left, release cycle included
    longint stalls;
  } mdl_t;

  // {en PC,IF_ID,ID_EX,EX_MEM,MEM_WB}, {flush IF_ID,ID_EX,EX_MEM,MEM_WB}, redirect, done
  typedef struct packed {
    logic [4:0] en;
    logic [3:0] fl;
    logic       redir;
    logic       done;
  } ctl_t;

  logic clk = 1'b0;
  logic rst;
  logic lu, br, md, req, rdy;
  int   n_checks = 0;
  int   n_fail   = 0;
  mdl_t ma, mb;

  always #5 clk = ~clk;

  pipeline_hold_ctrl_if #(.PERF_W(PW_A)) bus_a ();
  pipeline_hold_ctrl_if #(.PERF_W(PW_B)) bus_b ();

  assign bus_a.load_use_ID     = lu;
  assign bus_a.branch_taken_EX = br;
  assign bus_a.muldiv_EX       = md;
  assign bus_a.dmem_req_MEM    = req;
  assign bus_a.dmem_ready      = rdy;
  assign bus_b.load_use_ID     = lu;
  assign bus_b.branch_taken_EX = br;
  assign bus_b.muldiv_EX       = md;
  assign bus_b.dmem_req_MEM    = req;
  assign bus_b.dmem_ready      = rdy;

  pipeline_hold_ctrl #(.MULDIV_LAT(LAT_A), .CNT_W(6), .PERF_W(PW_A)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );

  pipeline_hold_ctrl #(.MULDIV_LAT(LAT_B), .CNT_W(6), .PERF_W(PW_B)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  logic [4:0] en_a, en_b;
  logic [3:0] fl_a, fl_b;
  assign en_a = {bus_a.en_PC, bus_a.en_IF_ID, bus_a.en_ID_EX, bus_a.en_EX_MEM, bus_a.en_MEM_WB};
  assign en_b = {bus_b.en_PC, bus_b.en_IF_ID, bus_b.en_ID_EX, bus_b.en_EX_MEM, bus_b.en_MEM_WB};
  assign fl_a = {bus_a.flush_IF_ID, bus_a.flush_ID_EX, bus_a.flush_EX_MEM, bus_a.flush_MEM_WB};
  assign fl_b = {bus_b.flush_IF_ID, bus_b.flush_ID_EX, bus_b.flush_EX_MEM, bus_b.flush_MEM_WB};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Freezing the first n stage registers inserts a bubble into register n
  // (or into MEM/WB itself when everything is frozen).
  function automatic ctl_t model_ctl(input mdl_t m, input logic r);
    ctl_t c;
    int   frz;
    int   bub;
    c.en    = 5'h1f;
    c.fl    = 4'h0;
    c.redir = 1'b0;
    c.done  = 1'b0;
    frz     = 0;
    if (r) begin
      c.fl = 4'hf;
      return c;
    end
    case (m.mode)
      MODE_MEM: if (!rdy) frz = 5;
      MODE_MUL: begin
        if (m.rem == 1) c.done = 1'b1;
        else            frz = 3;
      end
      default: begin
        if (req && !rdy)  frz = 5;
        else if (md)      frz = 3;
        else if (br) begin
          c.fl    = 4'b1100;
          c.redir = 1'b1;
        end
        else if (lu)      frz = 2;
      end
    endcase
    if (frz > 0) begin
      c.en = 5'h1f >> frz;
      bub  = (frz > 4) ? 4 : frz;
      c.fl[4 - bub] = 1'b1;
    end
    return c;
  endfunction

  function automatic mdl_t model_next(input mdl_t m, input int lat, input int pw,
                                      input logic r, input ctl_t c);
    mdl_t n;
    n = m;
    if (r) begin
      n.mode   = MODE_RUN;
      n.rem    = 0;
      n.stalls = 0;
      return n;
    end
    if (!c.en[4] && (n.stalls < ((longint'(1) << pw) - 1))) n.stalls++;
    case (m.mode)
      MODE_MEM: if (rdy) n.mode = MODE_RUN;
      MODE_MUL: begin
        if (m.rem == 1) n.mode = MODE_RUN;
        else            n.rem  = m.rem - 1;
      end
      default: begin
        if (req && !rdy) n.mode = MODE_MEM;
        else if (md) begin
          n.mode = MODE_MUL;
          n.rem  = lat - 1;
        end
      end
    endcase
    return n;
  endfunction

  // Compare both instances against the model at the falling edge, then advance.
  task automatic tick();
    ctl_t ca, cb;
    @(negedge clk);
    ca = model_ctl(ma, rst);
    cb = model_ctl(mb, rst);
    check("a_ctl",   64'({en_a, fl_a, bus_a.redirect_PC, bus_a.muldiv_done}), 64'(ca));
    check("a_state", 64'(bus_a.busy_state), 64'(ma.mode));
    check("a_stall", 64'(bus_a.stall_cycles), 64'(ma.stalls));
    check("b_ctl",   64'({en_b, fl_b, bus_b.redirect_PC, bus_b.muldiv_done}), 64'(cb));
    check("b_state", 64'(bus_b.busy_state), 64'(mb.mode));
    check("b_stall", 64'(bus_b.stall_cycles), 64'(mb.stalls));
    @(posedge clk);
    ma = model_next(ma, LAT_A, PW_A, rst, ca);
    mb = model_next(mb, LAT_B, PW_B, rst, cb);
    #1;
  endtask

  task automatic drive(input logic l, input logic b, input logic m,
                       input logic q, input logic y);
    lu  = l;
    br  = b;
    md  = m;
    req = q;
    rdy = y;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    lu = 1'b0; br = 1'b0; md = 1'b0; req = 1'b0; rdy = 1'b0;
    ma = '{MODE_RUN, 0, 0};
    mb = '{MODE_RUN, 0, 0};
    @(posedge clk);
    #1;
    tick();
    rst = 1'b0;

    // Idle
    drive(0, 0, 0, 0, 0);
    repeat (10) tick();
    check("idle_en",    64'(en_a), 64'h1f);
    check("idle_flush", 64'(fl_a), 64'h0);
    check("idle_stall", 64'(bus_a.stall_cycles), 64'd0);
    check("idle_state", 64'(bus_a.busy_state), 64'd0);

    // Load-use for one cycle
    drive(1, 0, 0, 0, 0);
    check("lu_en",    64'(en_a), 64'h07);
    check("lu_flush", 64'(fl_a), 64'h4);
    tick();
    drive(0, 0, 0, 0, 0);
    check("lu_after_en", 64'(en_a), 64'h1f);
    check("lu_stall",    64'(bus_a.stall_cycles), 64'd1);
    tick();

    // Branch beats load-use
    drive(1, 1, 0, 0, 0);
    check("br_flush", 64'(fl_a), 64'hc);
    check("br_redir", 64'(bus_a.redirect_PC), 64'd1);
    check("br_en_pc", 64'(bus_a.en_PC), 64'd1);
    tick();
    drive(0, 0, 0, 0, 0);
    check("br_stall", 64'(bus_a.stall_cycles), 64'd1);
    tick();

    // Mul/div held high, latency 4
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, 1, 0, 0);
      if (c > 0) check($sformatf("md_state_%0d", c), 64'(bus_a.busy_state), 64'd1);
      if (c < 3) begin
        check($sformatf("md_en_%0d", c),   64'(en_a), 64'h03);
        check($sformatf("md_fl_%0d", c),   64'(fl_a), 64'h2);
        check($sformatf("md_done_%0d", c), 64'(bus_a.muldiv_done), 64'd0);
      end else begin
        check("md_release_done", 64'(bus_a.muldiv_done), 64'd1);
        check("md_release_en",   64'(en_a), 64'h1f);
        check("md_release_fl",   64'(fl_a), 64'h0);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0);
    check("md_back_run", 64'(bus_a.busy_state), 64'd0);
    check("md_stall",    64'(bus_a.stall_cycles), 64'd4);
    tick();

    // Memory wait with a branch pending in EX
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, 0, 1, 0);
      check($sformatf("mem_en_%0d", c),    64'(en_a), 64'h00);
      check($sformatf("mem_fl_%0d", c),    64'(fl_a), 64'h1);
      check($sformatf("mem_redir_%0d", c), 64'(bus_a.redirect_PC), 64'd0);
      tick();
    end
    drive(0, 1, 0, 1, 1);
    check("mem_ready_en", 64'(en_a), 64'h1f);
    tick();
    drive(0, 1, 0, 0, 0);
    check("mem_after_redir", 64'(bus_a.redirect_PC), 64'd1);
    tick();

    // Reset mid mul/div on instance B (latency 8, counter at 5)
    drive(0, 0, 0, 0, 0);
    repeat (8) tick();
    drive(0, 0, 1, 0, 0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("rst_b_fl",   64'(fl_b), 64'hf);
    check("rst_b_en",   64'(en_b), 64'h1f);
    check("rst_b_done", 64'(bus_b.muldiv_done), 64'd0);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    check("rst_b_state", 64'(bus_b.busy_state), 64'd0);
    check("rst_b_stall", 64'(bus_b.stall_cycles), 64'd0);
    check("rst_b_nodone", 64'(bus_b.muldiv_done), 64'd0);
    repeat (10) tick();

    // Stall counter saturation on the 4-bit instance
    drive(1, 0, 0, 0, 0);
    repeat (20) tick();
    drive(0, 0, 0, 0, 0);
    check("sat_b", 64'(bus_b.stall_cycles), 64'd15);
    check("sat_a", 64'(bus_a.stall_cycles), 64'd20);
    tick();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
